// File: rtl/add_tree_stream_pkg.sv
// rtl/add_tree_stream_pkg.sv - shared types and sizing helpers for the add_tree_stream block
package add_tree_stream_pkg;

  typedef enum logic {GATHER, STALL} state_t;

  localparam int NUM_IN  = 8;
  localparam int LATENCY = 3;

  // Credits count 0..depth inclusive, so the counter needs room for depth itself.
  function automatic int credit_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/add_tree_stream_sum8_pipe.sv
// rtl/add_tree_stream_sum8_pipe.sv - 3-level registered 8-input adder tree with valid shift
// ADD_TREE_STREAM_OVF_EN widens each level by 3 bits and reports the carry-out.
module sum8_pipe
  import add_tree_stream_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_vec [NUM_IN],
  output logic             out_valid,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_carry
);

`ifdef ADD_TREE_STREAM_OVF_EN
  localparam int SW = WIDTH + 3;
`else
  localparam int SW = WIDTH;
`endif

  logic [SW-1:0] l1 [4];
  logic [SW-1:0] l2 [2];
  logic [SW-1:0] l3;
  logic          v1;
  logic          v2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1        <= 1'b0;
      v2        <= 1'b0;
      out_valid <= 1'b0;
      for (int i = 0; i < 4; i++) l1[i] <= '0;
      for (int i = 0; i < 2; i++) l2[i] <= '0;
      l3 <= '0;
    end else begin
      v1        <= in_valid;
      v2        <= v1;
      out_valid <= v2;
      for (int i = 0; i < 4; i++) l1[i] <= SW'(in_vec[2*i]) + SW'(in_vec[2*i+1]);
      for (int i = 0; i < 2; i++) l2[i] <= l1[2*i] + l1[2*i+1];
      l3 <= l2[0] + l2[1];
    end
  end

  assign out_sum = l3[WIDTH-1:0];

`ifdef ADD_TREE_STREAM_OVF_EN
  assign out_carry = |l3[SW-1:WIDTH];
`else
  assign out_carry = 1'b0;
`endif

endmodule

// File: rtl/add_tree_stream.sv
// rtl/add_tree_stream.sv - serial-to-8 gather, pipelined sum tree and credit-guarded FWFT result FIFO
// Optional carry-out reporting is enabled with ADD_TREE_STREAM_OVF_EN.
module add_tree_stream
  import add_tree_stream_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int OUT_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_ovf
);

  localparam int CW = credit_width(OUT_DEPTH);
  localparam int PW = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;

  state_t           state;
  logic [2:0]       cnt;
  logic [2:0]       cnt_nxt;
  logic [CW-1:0]    credits;
  logic [CW-1:0]    cred_nxt;
  logic             rdy_q;
  logic             stall_nxt;
  logic [WIDTH-1:0] slot [NUM_IN-1];
  logic [WIDTH-1:0] vec  [NUM_IN];
  logic             xfer, launch, pop, push;
  logic [WIDTH-1:0] tree_sum;
  logic             tree_carry;

  logic [WIDTH-1:0] mem_sum [OUT_DEPTH];
  logic             mem_ovf [OUT_DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    occ;

  assign in_ready = rdy_q;
  assign xfer     = in_valid && rdy_q;
  assign launch   = xfer && (cnt == 3'd7);
  assign pop      = out_valid && out_ready;
  assign cnt_nxt  = xfer ? cnt + 3'd1 : cnt;

  always_comb begin
    cred_nxt = credits;
    case ({launch, pop})
      2'b10:   cred_nxt = credits - CW'(1);
      2'b01:   cred_nxt = credits + CW'(1);
      default: cred_nxt = credits;
    endcase
  end

  assign stall_nxt = (cnt_nxt == 3'd7) && (cred_nxt == '0);

  // The 8th word bypasses the slots so the group launches on its own transfer edge.
  always_comb begin
    for (int i = 0; i < NUM_IN - 1; i++) vec[i] = slot[i];
    vec[NUM_IN-1] = in_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= GATHER;
      rdy_q   <= 1'b0;
      cnt     <= '0;
      credits <= CW'(OUT_DEPTH);
      for (int i = 0; i < NUM_IN - 1; i++) slot[i] <= '0;
    end else begin
      cnt     <= cnt_nxt;
      credits <= cred_nxt;
      if (xfer && cnt != 3'd7) slot[cnt] <= in_data;
      case (state)
        GATHER: begin
          if (stall_nxt) begin
            state <= STALL;
            rdy_q <= 1'b0;
          end else begin
            rdy_q <= 1'b1;
          end
        end
        STALL: begin
          if (!stall_nxt) begin
            state <= GATHER;
            rdy_q <= 1'b1;
          end
        end
      endcase
    end
  end

  sum8_pipe #(.WIDTH(WIDTH)) u_tree (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (launch),
    .in_vec    (vec),
    .out_valid (push),
    .out_sum   (tree_sum),
    .out_carry (tree_carry)
  );

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(OUT_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Credits reserve a slot at launch, so a push never finds the FIFO full.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
      for (int i = 0; i < OUT_DEPTH; i++) begin
        mem_sum[i] <= '0;
        mem_ovf[i] <= 1'b0;
      end
    end else begin
      if (push) begin
        mem_sum[wr_ptr] <= tree_sum;
        mem_ovf[wr_ptr] <= tree_carry;
        wr_ptr          <= ptr_inc(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   occ <= occ + CW'(1);
        2'b01:   occ <= occ - CW'(1);
        default: occ <= occ;
      endcase
    end
  end

  assign out_valid = (occ != '0);
  assign out_data  = mem_sum[rd_ptr];
  assign out_ovf   = mem_ovf[rd_ptr];

endmodule
